fir_serial_mac: RTL
===================

FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

Interface
REQ-001 Parameter NTAPS, default 8, SHALL set the number of FIR taps, which is also the number of MAC cycles per sample.
REQ-002 Parameter COEF_W, default 10, SHALL set the signed coefficient width.
REQ-003 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 in_data  input  30  SHALL be the signed sample from the upstream 30-bit register stage.
REQ-006 in_valid  input  1  SHALL indicate that in_data is valid.
REQ-007 in_ready  output  1  SHALL be high when a sample can be accepted.
REQ-008 coef_we  input  1  SHALL be the coefficient write strobe.
REQ-009 coef_addr  input  3  SHALL be the coefficient index, 0..NTAPS-1.
REQ-010 coef_data  input  COEF_W  SHALL be the signed coefficient value.
REQ-011 out_data  output  40  SHALL be the signed, saturated filter result.
REQ-012 out_valid  output  1  SHALL be a one-cycle result strobe.

Function
REQ-013 The FSM SHALL have states IDLE, MAC and DONE; in_ready SHALL equal (state==IDLE).
REQ-014 Acceptance SHALL occur on an edge where state==IDLE and in_valid==1.
REQ-015 On acceptance: tap[i] <= tap[i-1] for i=NTAPS-1..1, tap[0] <= in_data, accumulator cleared, tap index k <= 0, state -> MAC.
REQ-016 In MAC, each cycle SHALL add the full-precision signed product coef[k]*tap[k] (40-bit) into a 43-bit signed accumulator and increment k.
REQ-017 When k==NTAPS-1, the FSM SHALL register the final sum into out_data and go to DONE.
REQ-018 In DONE, out_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-019 out_valid SHALL be asserted exactly NTAPS+1 cycles after the accepting edge (9 for the default).
REQ-020 out_data SHALL hold its value until the next result; it SHALL be sign-correct and saturated to [-2^39, 2^39-1].
REQ-021 Throughput SHALL be one sample per NTAPS+2 cycles; in_valid while not IDLE SHALL be ignored and no sample SHALL be latched.
REQ-022 A coefficient write SHALL take effect only when coef_we==1 in IDLE; writes in MAC or DONE SHALL be dropped. Simultaneous write and acceptance SHALL update the coefficient before the MAC uses it.
REQ-023 coef_addr >= NTAPS SHALL be ignored.
REQ-024 The result SHALL be y = sum over i of coef[i]*tap[i], with tap[0] the newest sample.

Reset
REQ-025 While rst==0: all taps, coefficients, accumulator, k and out_data SHALL be 0; out_valid=0; state=IDLE; in_ready=1.
REQ-026 Reset asserted mid-MAC SHALL abort the computation with no out_valid pulse and no partial out_data update.
REQ-027 After rst deasserts, the first accepted sample SHALL see all other taps as 0.

Verification
REQ-028 Impulse: coef[i]=i+1, then samples 1,0,0,0,0,0,0,0,0 -> out_data 1,2,3,4,5,6,7,8,0, each out_valid exactly 9 cycles after its accept.
REQ-029 Saturation: all coef=511, eight samples 536870911 -> eighth output 549755813887. All coef=511, eight samples -536870912 -> eighth output -549755813888.
REQ-030 Signs: coef[0]=-512, sample -536870912 after reset -> out_data 274877906944.
REQ-031 Backpressure: in_valid held high with ramping data 1,2,3... -> one sample accepted every 10 cycles; in_ready low for 9 cycles after each accept; accepted samples are exactly those present on IDLE edges.
REQ-032 Coefficient lockout: coef_we to addr 0 during MAC -> current and next result use the old coef[0]; a write in IDLE takes effect on the next sample.
REQ-033 Reset mid-op: rst pulsed low at MAC cycle 4 -> no out_valid, out_data=0, in_ready=1; the next impulse reproduces REQ-028 with all coefficients 0 -> outputs 0.

Source files
------------

// File: rtl/fir_serial_mac_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fir_serial_mac_if                                         |
// | Purpose  : Sample, coefficient-write and result bundle for the       |
// |            serial-MAC FIR filter.                                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface fir_serial_mac_if #(
  parameter int COEF_W = 10
);
  logic signed [29:0]       in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     coef_we;
  logic [2:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic signed [39:0]       out_data;
  logic                     out_valid;

  // Upstream side: supplies samples and coefficients, consumes results.
  modport master (
    output in_data, in_valid, coef_we, coef_addr, coef_data,
    input  in_ready, out_data, out_valid
  );

  // Filter side.
  modport slave (
    input  in_data, in_valid, coef_we, coef_addr, coef_data,
    output in_ready, out_data, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/fir_serial_mac.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fir_serial_mac                                            |
// | Purpose  : NTAPS-tap FIR filter with a single time-shared multiplier. |
// |            One sample every NTAPS+2 cycles; saturated 40-bit result.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fir_serial_mac #(
  parameter int NTAPS  = 8,
  parameter int COEF_W = 10
) (
  input  wire logic       clk,
  input  wire logic       rst,
  fir_serial_mac_if.slave bus
);
  localparam int c_data_w = 30;
  localparam int c_prod_w = COEF_W + c_data_w;
  localparam int c_acc_w  = 43;
  localparam int c_out_w  = 40;
  localparam int c_k_w    = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  localparam logic [c_k_w-1:0]          c_k_last  = c_k_w'(NTAPS - 1);
  localparam logic signed [c_out_w-1:0] c_out_max = {1'b0, {(c_out_w-1){1'b1}}};
  localparam logic signed [c_out_w-1:0] c_out_min = {1'b1, {(c_out_w-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      r_state;
  logic signed [c_data_w-1:0]  r_tap  [NTAPS];
  logic signed [COEF_W-1:0]    r_coef [NTAPS];
  logic signed [c_acc_w-1:0]   r_acc;
  logic [c_k_w-1:0]            r_k;
  logic signed [c_out_w-1:0]   r_out_data;
  logic                        r_out_valid;

  logic signed [c_prod_w-1:0]  w_prod;
  logic signed [c_acc_w-1:0]   w_sum;
  logic signed [c_out_w-1:0]   w_sat;

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;

  // Full-precision product of the current tap pair and the running sum including it.
  always_comb begin
    w_prod = c_prod_w'(r_coef[r_k]) * c_prod_w'(r_tap[r_k]);
    w_sum  = r_acc + c_acc_w'(w_prod);
  end

  // Clamp the running sum into the 40-bit result range; in range when all guard bits match the sign.
  always_comb begin
    w_sat = w_sum[c_out_w-1:0];
    if (w_sum[c_acc_w-1:c_out_w-1] != {(c_acc_w-c_out_w+1){w_sum[c_acc_w-1]}}) begin
      w_sat = w_sum[c_acc_w-1] ? c_out_min : c_out_max;
    end
  end

  // Control FSM plus the datapath registers it sequences: accept, MAC sweep, result strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_k         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        r_tap[i]  <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // Coefficients are only writable here, so a sweep never sees a half-updated set.
          if (bus.coef_we) begin
            for (int i = 0; i < NTAPS; i++) begin
              if (int'(bus.coef_addr) == i) r_coef[i] <= bus.coef_data;
            end
          end
          if (bus.in_valid) begin
            for (int i = NTAPS - 1; i > 0; i--) r_tap[i] <= r_tap[i-1];
            r_tap[0] <= bus.in_data;
            r_acc    <= '0;
            r_k      <= '0;
            r_state  <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_sum;
          r_k   <= r_k + c_k_w'(1);
          if (r_k == c_k_last) begin
            r_out_data <= w_sat;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_out_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
